// File: rtl/message_extractor.sv
// Splits a 64-bit Avalon-ST packet of length-prefixed messages into one
// left-aligned 256-bit word plus byte mask per message.
module message_extractor #(
    parameter int MIN_LEN = 8,
    parameter int MAX_LEN = 32
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         in_valid,
    input  logic         in_startofpacket,
    input  logic         in_endofpacket,
    input  logic         in_error,
    input  logic [63:0]  in_data,
    input  logic [2:0]   in_empty,
    output logic         in_ready,
    output logic         out_valid,
    output logic [255:0] out_data,
    output logic [31:0]  out_bytemask
);

    typedef enum logic [2:0] {
        IDLE,
        CNT_HI,
        CNT_LO,
        LEN_HI,
        LEN_LO,
        PAYLOAD,
        DRAIN
    } state_t;

    typedef struct packed {
        state_t        state;
        logic [15:0]   cnt;
        logic [15:0]   len;
        logic [5:0]    idx;
        logic [255:0]  data;
    } ctx_t;

    typedef struct packed {
        ctx_t          ctx;
        logic          done;
        logic [5:0]    done_len;
        logic [255:0]  done_data;
    } beat_t;

    // Walks the valid bytes of one beat in order. A header plus the shortest
    // message is longer than a beat, so at most one message completes here.
    function automatic beat_t parse_beat(
        input ctx_t        start,
        input logic [63:0] bytes,
        input logic        sop,
        input logic        eop,
        input logic [2:0]  empty
    );
        beat_t      r;
        ctx_t       c;
        logic [7:0] b;
        logic [3:0] nbytes;
        c = start;
        if (sop) begin
            c = '0;
            c.state = CNT_HI;
        end
        r.done      = 1'b0;
        r.done_len  = '0;
        r.done_data = '0;
        nbytes = eop ? (4'd8 - {1'b0, empty}) : 4'd8;
        for (int i = 0; i < 8; i++) begin
            b = bytes[63-8*i -: 8];
            if (4'(i) < nbytes) begin
                case (c.state)
                    CNT_HI: begin
                        c.cnt[15:8] = b;
                        c.state = CNT_LO;
                    end
                    CNT_LO: begin
                        c.cnt[7:0] = b;
                        c.state = (c.cnt == 16'd0) ? DRAIN : LEN_HI;
                    end
                    LEN_HI: begin
                        c.len[15:8] = b;
                        c.state = LEN_LO;
                    end
                    LEN_LO: begin
                        c.len[7:0] = b;
                        if (c.len < 16'(MIN_LEN) || c.len > 16'(MAX_LEN)) begin
                            c.state = DRAIN;
                        end else begin
                            c.state = PAYLOAD;
                            c.idx   = '0;
                            c.data  = '0;
                        end
                    end
                    PAYLOAD: begin
                        c.data[255-8*int'(c.idx) -: 8] = b;
                        c.idx = c.idx + 6'd1;
                        if ({10'd0, c.idx} == c.len) begin
                            r.done      = 1'b1;
                            r.done_len  = c.len[5:0];
                            r.done_data = c.data;
                            c.cnt   = c.cnt - 16'd1;
                            c.state = (c.cnt == 16'd0) ? DRAIN : LEN_HI;
                        end
                    end
                    default: ;
                endcase
            end
        end
        // Anything still in flight at end of packet is abandoned.
        if (eop) begin
            c.state = IDLE;
        end
        r.ctx = c;
        return r;
    endfunction

    ctx_t  ctx;
    beat_t beat;
    logic  accept;

    assign accept = in_valid & in_ready;

    always_comb begin
        beat = parse_beat(ctx, in_data, in_startofpacket, in_endofpacket, in_empty);
    end

    always_ff @(posedge clk) begin
        if (reset_n) begin
            in_ready     <= 1'b0;
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_bytemask <= '0;
            ctx          <= '0;
        end else begin
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            if (accept) begin
                if (in_error) begin
                    ctx <= '0;
                end else begin
                    ctx <= beat.ctx;
                    if (beat.done) begin
                        out_valid    <= 1'b1;
                        out_data     <= beat.done_data;
                        out_bytemask <= ~(32'hFFFF_FFFF >> beat.done_len);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_message_extractor.sv
// Directed bench for message_extractor: packets built from byte lists, every
// emitted message matched against an expected queue of {mask, data}.
module tb_message_extractor;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         in_valid;
    logic         in_startofpacket;
    logic         in_endofpacket;
    logic         in_error;
    logic [63:0]  in_data;
    logic [2:0]   in_empty;
    logic         in_ready;
    logic         out_valid;
    logic [255:0] out_data;
    logic [31:0]  out_bytemask;

    int n_checks = 0;
    int n_pass   = 0;
    int pulses   = 0;
    int p0;

    logic [287:0] exp_q[$];
    logic [7:0]   pkt_q[$];

    message_extractor dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .in_valid         (in_valid),
        .in_startofpacket (in_startofpacket),
        .in_endofpacket   (in_endofpacket),
        .in_error         (in_error),
        .in_data          (in_data),
        .in_empty         (in_empty),
        .in_ready         (in_ready),
        .out_valid        (out_valid),
        .out_data         (out_data),
        .out_bytemask     (out_bytemask)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [287:0] got, input logic [287:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_beat(input logic [63:0] d, input logic sop, input logic eop,
                              input logic err, input logic [2:0] empty);
        in_valid         = 1'b1;
        in_data          = d;
        in_startofpacket = sop;
        in_endofpacket   = eop;
        in_error         = err;
        in_empty         = empty;
        @(posedge clk);
        #1;
        in_valid         = 1'b0;
        in_startofpacket = 1'b0;
        in_endofpacket   = 1'b0;
        in_error         = 1'b0;
    endtask

    task automatic push_hdr(input int count);
        pkt_q.push_back(8'(count >> 8));
        pkt_q.push_back(8'(count));
    endtask

    // Payload byte k = base + k*step; expected word is built by shifting in.
    task automatic push_msg(input int len, input logic [7:0] base, input logic [7:0] step,
                            input bit expect_out);
        logic [255:0] d;
        logic [31:0]  m;
        logic [7:0]   b;
        d = '0;
        m = '0;
        pkt_q.push_back(8'(len >> 8));
        pkt_q.push_back(8'(len));
        for (int k = 0; k < len; k++) begin
            b = base + 8'(k) * step;
            pkt_q.push_back(b);
            d = {d[247:0], b};
        end
        if (expect_out) begin
            d = d << (8 * (32 - len));
            for (int k = 0; k < len; k++) m[31-k] = 1'b1;
            exp_q.push_back({m, d});
        end
    endtask

    // Sends beats first..last of pkt_q (last<0: through the end).
    task automatic send_pkt(input int err_beat, input int first, input int last, input int empty_ovr);
        int n, nb, idx, stop;
        logic [63:0] d;
        logic [2:0]  e;
        n  = pkt_q.size();
        nb = (n + 7) / 8;
        stop = (last < 0) ? nb - 1 : last;
        for (int bt = first; bt <= stop; bt++) begin
            d = '0;
            for (int j = 0; j < 8; j++) begin
                idx = bt * 8 + j;
                d = {d[55:0], (idx < n) ? pkt_q[idx] : 8'h00};
            end
            e = (bt == nb - 1) ? 3'(nb * 8 - n) : 3'd0;
            if (empty_ovr >= 0 && bt == nb - 1) e = 3'(empty_ovr);
            drive_beat(d, bt == 0, bt == nb - 1, bt == err_beat, e);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (out_valid) begin
                pulses++;
                if (exp_q.size() == 0) check("unexpected_out", 288'(out_valid), 288'd0);
                else check("msg", {out_bytemask, out_data}, exp_q.pop_front());
            end
        end
    end

    initial begin
        reset_n = 1'b1;
        in_valid = 1'b0;
        in_startofpacket = 1'b0;
        in_endofpacket = 1'b0;
        in_error = 1'b0;
        in_data = '0;
        in_empty = '0;
        idle(2);
        check("rst_in_ready", 288'(in_ready), 288'd0);
        check("rst_out", {out_bytemask, out_data}, 288'd0);
        check("rst_out_valid", 288'(out_valid), 288'd0);
        reset_n = 1'b0;
        idle(1);
        check("in_ready_up", 288'(in_ready), 288'd1);

        // Reference packet: 8 messages, 15 beats, last beat empty=6
        push_hdr(8);
        push_msg(8,  8'h62, 8'h00, 1);
        push_msg(12, 8'h68, 8'h00, 1);
        push_msg(10, 8'h70, 8'h00, 1);
        push_msg(15, 8'h7a, 8'h00, 1);
        push_msg(14, 8'h4d, 8'h00, 1);
        push_msg(17, 8'h38, 8'h00, 1);
        push_msg(11, 8'h31, 8'h00, 1);
        push_msg(9,  8'h5a, 8'h00, 1);
        p0 = pulses;
        send_pkt(-1, 0, -1, -1);
        pkt_q.delete();
        idle(3);
        check("ref_pulses", 288'(pulses - p0), 288'd8);
        check("ref_hold", {out_bytemask, out_data}, {32'hFF800000, 72'h5a5a5a5a5a5a5a5a5a, 184'd0});

        // Length 32 across five beats, then length 33 drains
        push_hdr(2);
        push_msg(32, 8'h01, 8'h01, 1);
        push_msg(33, 8'hc0, 8'h00, 0);
        push_msg(8,  8'h33, 8'h00, 0);
        p0 = pulses;
        send_pkt(-1, 0, -1, -1);
        pkt_q.delete();
        idle(3);
        check("len32_pulses", 288'(pulses - p0), 288'd1);
        check("len32_mask", 288'(out_bytemask), 288'(32'hFFFFFFFF));

        // EOP with empty=2 cuts a 12-byte message after 10 bytes
        push_hdr(1);
        pkt_q.push_back(8'h00);
        pkt_q.push_back(8'h0c);
        for (int k = 0; k < 12; k++) pkt_q.push_back(8'h90 + 8'(k));
        p0 = pulses;
        send_pkt(-1, 0, -1, 2);
        pkt_q.delete();
        idle(3);
        check("trunc_pulses", 288'(pulses - p0), 288'd0);
        push_hdr(1);
        push_msg(8, 8'h11, 8'h11, 1);
        p0 = pulses;
        send_pkt(-1, 0, -1, -1);
        pkt_q.delete();
        idle(3);
        check("after_trunc_pulses", 288'(pulses - p0), 288'd1);

        // Error on the beat that completes the first message
        push_hdr(2);
        push_msg(8, 8'h21, 8'h00, 0);
        push_msg(8, 8'h22, 8'h00, 0);
        p0 = pulses;
        send_pkt(1, 0, -1, -1);
        pkt_q.delete();
        idle(3);
        check("err_pulses", 288'(pulses - p0), 288'd0);

        // SOP in mid-packet restarts parsing
        push_hdr(1);
        push_msg(20, 8'he0, 8'h00, 0);
        send_pkt(-1, 0, 1, -1);
        pkt_q.delete();
        push_hdr(1);
        push_msg(10, 8'h50, 8'h03, 1);
        p0 = pulses;
        send_pkt(-1, 0, -1, -1);
        pkt_q.delete();
        idle(3);
        check("restart_pulses", 288'(pulses - p0), 288'd1);

        // One-cycle reset mid-packet
        push_hdr(1);
        push_msg(16, 8'h40, 8'h01, 0);
        p0 = pulses;
        send_pkt(-1, 0, 0, -1);
        reset_n = 1'b1;
        idle(1);
        check("midrst_in_ready", 288'(in_ready), 288'd0);
        check("midrst_out", {out_bytemask, out_data}, 288'd0);
        reset_n = 1'b0;
        send_pkt(-1, 1, -1, -1);
        pkt_q.delete();
        idle(3);
        check("midrst_in_ready_up", 288'(in_ready), 288'd1);
        check("midrst_pulses", 288'(pulses - p0), 288'd0);

        // Count=1 with a well-formed trailing message that must be ignored
        push_hdr(1);
        push_msg(9, 8'h70, 8'h01, 1);
        push_msg(8, 8'h99, 8'h00, 0);
        p0 = pulses;
        send_pkt(-1, 0, -1, -1);
        pkt_q.delete();
        idle(3);
        check("count1_pulses", 288'(pulses - p0), 288'd1);

        check("exp_q_left", 288'(exp_q.size()), 288'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
